rsa_uart_wrapper: RTL and testbench

- Avalon-MM master that sits between the RS232 UART IP and the RSA256 decryption core.
- Polls the UART and assembles the 256-bit modulus N, the private key d and each 256-bit ciphertext block from incoming bytes.
- Launches the core on each ciphertext block, then streams the plaintext back out through the UART.
- Key and modulus are loaded once after reset; ciphertext blocks repeat indefinitely.

---
 rtl/rsa_uart_wrapper_if.sv | 27 ++
 rtl/rsa_uart_wrapper.sv | 189 ++++++++++++++++++
 tb/tb_rsa_uart_wrapper.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_uart_wrapper_if.sv
// Avalon-MM link between the RSA/UART wrapper (master) and the UART register block (slave).
interface rsa_uart_wrapper_if;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_writedata,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/rsa_uart_wrapper.sv
// Polls the UART for N, d and ciphertext bytes, runs the RSA256 core on each block
// and streams the plaintext back out through the UART.
module rsa_uart_wrapper #(
  parameter logic [4:0]  RX_ADDR     = 5'd0,
  parameter logic [4:0]  TX_ADDR     = 5'd1,
  parameter logic [4:0]  STATUS_ADDR = 5'd2,
  parameter int unsigned RRDY_BIT    = 7,
  parameter int unsigned TRDY_BIT    = 6,
  parameter int unsigned IN_BYTES    = 32,
  parameter int unsigned OUT_BYTES   = 31
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  rsa_uart_wrapper_if.master        avm,
  output logic                      o_core_start,
  output logic [255:0]              o_core_n,
  output logic [255:0]              o_core_key,
  output logic [255:0]              o_core_msg,
  input  logic [255:0]              i_core_ans,
  input  logic                      i_core_finished
);

  localparam int unsigned SEND_W = OUT_BYTES * 8;
  localparam int unsigned MAX_BYTES = (IN_BYTES > OUT_BYTES) ? IN_BYTES : OUT_BYTES;
  localparam int unsigned CNT_W = $clog2(MAX_BYTES);
  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_BYTES - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_BYTES - 1);

  typedef enum logic [2:0] {
    S_QUERY_RX,
    S_READ,
    S_WAIT_CORE,
    S_QUERY_TX,
    S_WRITE
  } state_t;

  typedef enum logic [1:0] {
    PH_N,
    PH_KEY,
    PH_MSG
  } phase_t;

  state_t             state;
  phase_t             phase;
  logic [CNT_W-1:0]   cnt;
  logic [255:0]       n_r;
  logic [255:0]       key_r;
  logic [255:0]       msg_r;
  logic [SEND_W-1:0]  send_r;
  logic [4:0]         addr_r;
  logic               rd_r;
  logic               wr_r;
  logic               start_r;

  logic               xfer_done;
  logic [7:0]         rx_byte;
  logic               unused_bits;

  assign xfer_done = (rd_r | wr_r) & ~avm.avm_waitrequest;
  assign rx_byte   = avm.avm_readdata[7:0];

  assign avm.avm_address   = addr_r;
  assign avm.avm_read      = rd_r;
  assign avm.avm_write     = wr_r;
  assign avm.avm_writedata = {24'h0, send_r[SEND_W-1 -: 8]};

  assign o_core_start = start_r;
  assign o_core_n     = n_r;
  assign o_core_key   = key_r;
  assign o_core_msg   = msg_r;

  // Upper readdata bits and the top answer byte carry nothing this block needs.
  assign unused_bits = ^{avm.avm_readdata, i_core_ans[255:SEND_W]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_QUERY_RX;
      phase   <= PH_N;
      cnt     <= '0;
      n_r     <= '0;
      key_r   <= '0;
      msg_r   <= '0;
      send_r  <= '0;
      addr_r  <= STATUS_ADDR;
      rd_r    <= 1'b1;
      wr_r    <= 1'b0;
      start_r <= 1'b0;
    end else begin
      start_r <= 1'b0;
      case (state)
        S_QUERY_RX: begin
          if (xfer_done && avm.avm_readdata[RRDY_BIT]) begin
            state  <= S_READ;
            addr_r <= RX_ADDR;
          end
        end

        S_READ: begin
          if (xfer_done) begin
            case (phase)
              PH_N:    n_r   <= {n_r[247:0], rx_byte};
              PH_KEY:  key_r <= {key_r[247:0], rx_byte};
              default: msg_r <= {msg_r[247:0], rx_byte};
            endcase
            if (cnt == IN_LAST) begin
              cnt <= '0;
              case (phase)
                PH_N:    phase <= PH_KEY;
                default: phase <= PH_MSG;
              endcase
              if (phase == PH_MSG) begin
                state   <= S_WAIT_CORE;
                rd_r    <= 1'b0;
                start_r <= 1'b1;
              end else begin
                state  <= S_QUERY_RX;
                addr_r <= STATUS_ADDR;
              end
            end else begin
              cnt    <= cnt + 1'b1;
              state  <= S_QUERY_RX;
              addr_r <= STATUS_ADDR;
            end
          end
        end

        S_WAIT_CORE: begin
          if (i_core_finished) begin
            send_r <= i_core_ans[SEND_W-1:0];
            cnt    <= '0;
            state  <= S_QUERY_TX;
            rd_r   <= 1'b1;
            addr_r <= STATUS_ADDR;
          end
        end

        S_QUERY_TX: begin
          if (xfer_done && avm.avm_readdata[TRDY_BIT]) begin
            state  <= S_WRITE;
            rd_r   <= 1'b0;
            wr_r   <= 1'b1;
            addr_r <= TX_ADDR;
          end
        end

        S_WRITE: begin
          if (xfer_done) begin
            send_r <= {send_r[SEND_W-9:0], 8'h00};
            wr_r   <= 1'b0;
            rd_r   <= 1'b1;
            addr_r <= STATUS_ADDR;
            // After the last byte only a new ciphertext is collected; N and d are kept.
            if (cnt == OUT_LAST) begin
              cnt   <= '0;
              state <= S_QUERY_RX;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_QUERY_TX;
            end
          end
        end

        default: begin
          state  <= S_QUERY_RX;
          rd_r   <= 1'b1;
          wr_r   <= 1'b0;
          addr_r <= STATUS_ADDR;
        end
      endcase
    end
  end

  a_hold_under_stall: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    ((rd_r | wr_r) && avm.avm_waitrequest) |=>
      ($stable(addr_r) && $stable(rd_r) && $stable(wr_r) && $stable(avm.avm_writedata))
  );

  a_single_command: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    (state == S_WAIT_CORE) ? !(rd_r | wr_r) : (rd_r ^ wr_r)
  );

  a_start_only_with_key: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    start_r |-> (phase == PH_MSG && state == S_WAIT_CORE)
  );

endmodule

// File: tb/tb_rsa_uart_wrapper.sv
// Randomised bench: UART register model and RSA core model around rsa_uart_wrapper.
module tb_rsa_uart_wrapper;

  localparam logic [255:0] N_CONST =
    256'hCA3586E7EA485F3B0A222A4C79F7DD12E85388ECCDEE4035940D774C029CF831;

  typedef struct {
    logic [4:0] addr;
    bit         wr;
    logic [7:0] data;
  } xact_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rsa_uart_wrapper_if avm_if ();

  logic         core_start;
  logic         core_finished = 1'b0;
  logic [255:0] core_n;
  logic [255:0] core_key;
  logic [255:0] core_msg;
  logic [255:0] core_ans = '0;

  rsa_uart_wrapper #(
    .RX_ADDR     (5'd0),
    .TX_ADDR     (5'd1),
    .STATUS_ADDR (5'd2)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .avm             (avm_if),
    .o_core_start    (core_start),
    .o_core_n        (core_n),
    .o_core_key      (core_key),
    .o_core_msg      (core_msg),
    .i_core_ans      (core_ans),
    .i_core_finished (core_finished)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // UART register model
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  xact_t      log_q[$];
  int   rx_gate = 0, tx_gate = 0;
  bit   rand_gates = 0, rand_stall = 0, stall_all = 0;
  int   stall_left = 0, write_stall_at = -1, wr_done = 0;
  bit   in_stall = 0;
  int   rx_read_cnt = 0, hold_viol = 0, wd_hi_bad = 0, rx_underflow = 0;
  logic [4:0]  snap_addr;
  logic        snap_rd, snap_wr;
  logic [31:0] snap_wd;
  logic [7:0]  sd;
  logic [31:0] rdw;
  xact_t       xa;

  // Core model
  int   start_cnt = 0, pending = -1, core_latency = 1000, msg_changed = 0, rx_at_start = 0;
  bit   spurious = 0;
  logic [255:0] cap_n, cap_key, cap_msg, next_ans, spur_ans;

  // Reference values shared between scenarios
  logic [255:0] nv, key_val;

  always @(negedge clk) begin
    if (!rst_n) begin
      avm_if.avm_waitrequest = 1'b0;
      avm_if.avm_readdata    = '0;
      in_stall   = 0;
      stall_left = 0;
    end else if (avm_if.avm_read || avm_if.avm_write) begin
      if (in_stall) begin
        if (avm_if.avm_address !== snap_addr || avm_if.avm_read !== snap_rd ||
            avm_if.avm_write !== snap_wr || avm_if.avm_writedata !== snap_wd)
          hold_viol++;
      end else begin
        snap_addr  = avm_if.avm_address;
        snap_rd    = avm_if.avm_read;
        snap_wr    = avm_if.avm_write;
        snap_wd    = avm_if.avm_writedata;
        stall_left = rand_stall ? int'($urandom_range(0, 2)) : 0;
        if (avm_if.avm_write && wr_done == write_stall_at) stall_left = 3;
      end
      if (stall_all || stall_left > 0) begin
        avm_if.avm_waitrequest = 1'b1;
        avm_if.avm_readdata    = $urandom;
        in_stall = 1;
        if (stall_left > 0) stall_left--;
      end else begin
        avm_if.avm_waitrequest = 1'b0;
        in_stall = 0;
        xa.addr = avm_if.avm_address;
        xa.wr   = avm_if.avm_write;
        rdw     = $urandom;
        sd      = 8'h00;
        if (avm_if.avm_write) begin
          sd = avm_if.avm_writedata[7:0];
          if (avm_if.avm_writedata[31:8] !== 24'h0) wd_hi_bad++;
          tx_q.push_back(sd);
          wr_done++;
          tx_gate = rand_gates ? int'($urandom_range(0, 2)) : 0;
        end else if (avm_if.avm_address == 5'd2) begin
          if (rx_gate > 0) rx_gate--;
          else if (rx_q.size() > 0) sd[7] = 1'b1;
          if (tx_gate > 0) tx_gate--;
          else sd[6] = 1'b1;
        end else if (avm_if.avm_address == 5'd0) begin
          if (rx_q.size() > 0) sd = rx_q.pop_front();
          else begin
            sd = 8'($urandom);
            rx_underflow++;
          end
          rx_read_cnt++;
          rx_gate = rand_gates ? int'($urandom_range(0, 2)) : 0;
        end else begin
          sd = 8'($urandom);
        end
        rdw[7:0] = sd;
        avm_if.avm_readdata = rdw;
        xa.data = sd;
        log_q.push_back(xa);
      end
    end else begin
      avm_if.avm_waitrequest = 1'($urandom_range(0, 1));
      in_stall = 0;
    end
  end

  always @(negedge clk) begin
    core_finished = 1'b0;
    if (!rst_n) begin
      pending  = -1;
      core_ans = '0;
    end else begin
      if (spurious) begin
        core_finished = 1'b1;
        core_ans = spur_ans;
        spurious = 0;
      end else if (pending == 0) begin
        core_finished = 1'b1;
        core_ans = next_ans;
        pending  = -1;
        if (core_msg !== cap_msg) msg_changed++;
      end else if (pending > 0) begin
        pending--;
      end
      if (core_start) begin
        start_cnt++;
        cap_n   = core_n;
        cap_key = core_key;
        cap_msg = core_msg;
        rx_at_start = rx_read_cnt;
        pending = core_latency;
      end
    end
  end

  function automatic logic [7:0] ans_byte(input logic [255:0] a, input int k);
    return 8'(a >> (8 * (30 - k)));
  endfunction

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    rx_q.delete(); tx_q.delete(); log_q.delete();
    rx_gate = 0; tx_gate = 0; rand_gates = 0; rand_stall = 0; stall_all = 0;
    write_stall_at = -1; wr_done = 0; rx_read_cnt = 0; start_cnt = 0;
    hold_viol = 0; wd_hi_bad = 0; rx_underflow = 0; msg_changed = 0; spurious = 0;
    repeat (3) @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int c;
    apply_reset();
    for (int i = 0; i < 5; i++) rx_q.push_back(8'($urandom_range(1, 255)));
    c = 0;
    while (rx_read_cnt < 5 && c < 300) begin @(posedge clk); c++; end
    n_cmp++;
    if (rx_read_cnt !== 5) begin
      n_bad++; $display("FAIL reset_preload: rx reads %0d, required 5", rx_read_cnt);
    end
    stall_all = 1;
    repeat (4) @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (avm_if.avm_read !== 1'b1) begin n_bad++; $display("FAIL reset_read: got %b, required 1", avm_if.avm_read); end
    n_cmp++;
    if (avm_if.avm_write !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %b, required 0", avm_if.avm_write); end
    n_cmp++;
    if (avm_if.avm_address !== 5'd2) begin n_bad++; $display("FAIL reset_addr: got %0d, required 2", avm_if.avm_address); end
    n_cmp++;
    if (core_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b, required 0", core_start); end
    n_cmp++;
    if (core_n !== '0 || core_key !== '0 || core_msg !== '0) begin
      n_bad++; $display("FAIL reset_regs: n=%h key=%h msg=%h, required all zero", core_n, core_key, core_msg);
    end
    repeat (2) @(posedge clk); #2;
    stall_all = 0;
    rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    n_cmp++;
    if (start_cnt !== 0) begin n_bad++; $display("FAIL reset_no_start: starts %0d, required 0", start_cnt); end
    n_cmp++;
    if (avm_if.avm_read !== 1'b1 || avm_if.avm_address !== 5'd2) begin
      n_bad++; $display("FAIL reset_repoll: read=%b addr=%0d, required read=1 addr=2", avm_if.avm_read, avm_if.avm_address);
    end
  endtask

  // Continues from the post-reset state: a misaligned byte counter would corrupt N here.
  task automatic test_key_load();
    logic [255:0] m_val;
    int c;
    rx_read_cnt = 0; start_cnt = 0; log_q.delete(); tx_q.delete(); rx_underflow = 0;
    rand_gates = 1; rand_stall = 1; rx_gate = 0; tx_gate = 0;
    nv = N_CONST;
    key_val = {16'h0BB7, 240'h0};
    for (int w = 0; w < 15; w++) key_val[w*16 +: 16] = 16'($urandom);
    for (int w = 0; w < 8; w++) m_val[w*32 +: 32] = $urandom;
    next_ans = '0;
    for (int k = 0; k < 31; k++) next_ans[247 - 8*k -: 8] = 8'(8'h41 + k);
    core_latency = 1000;
    wr_done = 0; write_stall_at = 4;
    for (int i = 31; i >= 0; i--) rx_q.push_back(nv[i*8 +: 8]);
    for (int i = 31; i >= 0; i--) rx_q.push_back(key_val[i*8 +: 8]);
    for (int i = 31; i >= 0; i--) rx_q.push_back(m_val[i*8 +: 8]);
    c = 0;
    while (start_cnt < 1 && c < 4000) begin @(posedge clk); c++; end
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (start_cnt !== 1) begin n_bad++; $display("FAIL load_start_count: got %0d, required 1", start_cnt); end
    n_cmp++;
    if (cap_n !== nv) begin n_bad++; $display("FAIL load_n: got %h, required %h", cap_n, nv); end
    n_cmp++;
    if (cap_key !== key_val) begin n_bad++; $display("FAIL load_key: got %h, required %h", cap_key, key_val); end
    n_cmp++;
    if (cap_msg !== m_val) begin n_bad++; $display("FAIL load_msg: got %h, required %h", cap_msg, m_val); end
    n_cmp++;
    if (rx_at_start !== 96) begin n_bad++; $display("FAIL load_rx_reads: got %0d, required 96", rx_at_start); end
    n_cmp++;
    if (rx_underflow !== 0) begin n_bad++; $display("FAIL load_underflow: got %0d, required 0", rx_underflow); end
    n_cmp++;
    if (avm_if.avm_read !== 1'b0 || avm_if.avm_write !== 1'b0) begin
      n_bad++; $display("FAIL load_bus_idle: read=%b write=%b, required 0 0", avm_if.avm_read, avm_if.avm_write);
    end
  endtask

  task automatic test_tx_stream();
    int c;
    c = 0;
    while (tx_q.size() < 31 && c < 3000) begin @(posedge clk); c++; end
    repeat (60) @(posedge clk); #1;
    n_cmp++;
    if (tx_q.size() !== 31) begin n_bad++; $display("FAIL tx_count: got %0d, required 31", tx_q.size()); end
    for (int k = 0; k < 31 && k < tx_q.size(); k++) begin
      n_cmp++;
      if (tx_q[k] !== ans_byte(next_ans, k)) begin
        n_bad++; $display("FAIL tx_byte[%0d]: got %h, required %h", k, tx_q[k], ans_byte(next_ans, k));
      end
    end
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].wr) begin
        n_cmp++;
        if (i == 0 || log_q[i].addr !== 5'd1 || log_q[i-1].wr || log_q[i-1].addr !== 5'd2 ||
            log_q[i-1].data[6] !== 1'b1) begin
          n_bad++; $display("FAIL tx_order[%0d]: write addr %0d not preceded by TX-ready status read", i, log_q[i].addr);
        end
      end
    end
    n_cmp++;
    if (hold_viol !== 0) begin n_bad++; $display("FAIL tx_hold: violations %0d, required 0", hold_viol); end
    n_cmp++;
    if (wd_hi_bad !== 0) begin n_bad++; $display("FAIL tx_upper_zero: violations %0d, required 0", wd_hi_bad); end
    n_cmp++;
    if (msg_changed !== 0) begin n_bad++; $display("FAIL tx_msg_stable: changes %0d, required 0", msg_changed); end
    n_cmp++;
    if (avm_if.avm_read !== 1'b1 || avm_if.avm_address !== 5'd2) begin
      n_bad++; $display("FAIL tx_back_to_rx: read=%b addr=%0d, required read=1 addr=2", avm_if.avm_read, avm_if.avm_address);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] m_val;
    int c;
    for (int blk = 0; blk < 2; blk++) begin
      log_q.delete(); tx_q.delete();
      start_cnt = 0; rx_read_cnt = 0; write_stall_at = -1; wr_done = 0;
      if (blk == 0) begin
        for (int w = 0; w < 8; w++) spur_ans[w*32 +: 32] = $urandom;
        spurious = 1;
        repeat (40) @(posedge clk); #1;
        n_cmp++;
        if (tx_q.size() !== 0) begin
          n_bad++; $display("FAIL spurious_finish: tx bytes %0d, required 0", tx_q.size());
        end
      end
      for (int w = 0; w < 8; w++) m_val[w*32 +: 32] = $urandom;
      for (int w = 0; w < 8; w++) next_ans[w*32 +: 32] = $urandom;
      core_latency = int'($urandom_range(5, 100));
      for (int i = 31; i >= 0; i--) rx_q.push_back(m_val[i*8 +: 8]);
      c = 0;
      while (start_cnt < 1 && c < 2000) begin @(posedge clk); c++; end
      repeat (3) @(posedge clk); #1;
      n_cmp++;
      if (start_cnt !== 1) begin n_bad++; $display("FAIL b2b_start[%0d]: got %0d, required 1", blk, start_cnt); end
      n_cmp++;
      if (rx_at_start !== 32) begin n_bad++; $display("FAIL b2b_rx_reads[%0d]: got %0d, required 32", blk, rx_at_start); end
      n_cmp++;
      if (cap_msg !== m_val) begin n_bad++; $display("FAIL b2b_msg[%0d]: got %h, required %h", blk, cap_msg, m_val); end
      n_cmp++;
      if (cap_key !== key_val || cap_n !== nv) begin
        n_bad++; $display("FAIL b2b_key_n[%0d]: key=%h n=%h, required key=%h n=%h", blk, cap_key, cap_n, key_val, nv);
      end
      c = 0;
      while (tx_q.size() < 31 && c < 2000) begin @(posedge clk); c++; end
      repeat (30) @(posedge clk); #1;
      n_cmp++;
      if (tx_q.size() !== 31) begin n_bad++; $display("FAIL b2b_tx_count[%0d]: got %0d, required 31", blk, tx_q.size()); end
      for (int k = 0; k < 31 && k < tx_q.size(); k++) begin
        n_cmp++;
        if (tx_q[k] !== ans_byte(next_ans, k)) begin
          n_bad++; $display("FAIL b2b_tx_byte[%0d][%0d]: got %h, required %h", blk, k, tx_q[k], ans_byte(next_ans, k));
        end
      end
      n_cmp++;
      if (hold_viol !== 0 || msg_changed !== 0) begin
        n_bad++; $display("FAIL b2b_stability[%0d]: hold=%0d msg=%0d, required 0 0", blk, hold_viol, msg_changed);
      end
    end
  endtask

  task automatic test_rx_poll();
    logic [7:0] b;
    int c, rx_reads;
    apply_reset();
    tx_gate = 1000;
    rx_gate = 5;
    b = 8'($urandom);
    rx_q.push_back(b);
    c = 0;
    while (log_q.size() < 9 && c < 200) begin @(posedge clk); c++; end
    n_cmp++;
    if (log_q.size() < 9) begin
      n_bad++; $display("FAIL poll_timeout: transfers %0d, required at least 9", log_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        logic [4:0] ea;
        logic [7:0] ed;
        ea = (i == 6) ? 5'd0 : 5'd2;
        ed = (i == 6) ? b : ((i == 5) ? 8'h80 : 8'h00);
        n_cmp++;
        if (log_q[i].wr || log_q[i].addr !== ea || log_q[i].data !== ed) begin
          n_bad++; $display("FAIL poll_seq[%0d]: wr=%0d addr=%0d data=%h, required read addr=%0d data=%h",
                            i, log_q[i].wr, log_q[i].addr, log_q[i].data, ea, ed);
        end
      end
    end
    repeat (10) @(posedge clk); #1;
    rx_reads = 0;
    foreach (log_q[i]) if (!log_q[i].wr && log_q[i].addr == 5'd0) rx_reads++;
    n_cmp++;
    if (rx_reads !== 1) begin n_bad++; $display("FAIL poll_single_rx: got %0d, required 1", rx_reads); end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_key_load();
    test_tx_stream();
    test_back_to_back();
    test_rx_poll();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
